// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the 16-bit MIPS core.
// Parses a big-endian byte stream (2-byte word count, then 16-bit words)
// and writes it into instruction memory while holding the core in reset.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reload,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DAT_HI,
    DAT_LO,
    RUN,
    ERR
  } state_t;

  // Largest legal word count: a completely full instruction memory.
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t            state;
  logic [7:0]        cnt_hi_q;   // header high byte, waiting for its partner
  logic [15:0]       count_q;    // number of words in the image
  logic [7:0]        hold_q;     // instruction high byte, waiting for its partner
  logic [ADDR_W:0]   idx_q;      // one extra bit so a full image is countable

  logic              accept;
  logic [15:0]       hdr;
  logic              hdr_bad;
  logic              last_word;

  assign accept    = in_valid && in_ready;
  assign hdr       = {cnt_hi_q, in_data};
  assign hdr_bad   = (hdr == 16'd0) || ({1'b0, hdr} > CAP);
  assign last_word = (17'(idx_q) + 17'd1) == {1'b0, count_q};

  // Stream is open in every state except RUN, and RUN is the only state
  // in which the core is allowed to execute.
  assign in_ready = (state != RUN);
  assign cpu_hold = (state != RUN);

  // Header parse, word assembly and the registered memory write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CNT_HI;
      cnt_hi_q  <= '0;
      count_q   <= '0;
      hold_q    <= '0;
      idx_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere in this block; these
      // defaults make mem_we/done single-cycle pulses unless a case below
      // overrides them later in the same edge.
      mem_we <= 1'b0;
      done   <= 1'b0;
      if (reload) begin
        // A byte accepted in this same cycle is deliberately dropped.
        state <= CNT_HI;
        err   <= 1'b0;
        idx_q <= '0;
      end else begin
        case (state)
          CNT_HI: if (accept) begin
            cnt_hi_q <= in_data;
            state    <= CNT_LO;
          end
          CNT_LO: if (accept) begin
            count_q <= hdr;
            idx_q   <= '0;
            if (hdr_bad) begin
              err   <= 1'b1;
              state <= ERR;
            end else begin
              state <= DAT_HI;
            end
          end
          DAT_HI: if (accept) begin
            hold_q <= in_data;
            state  <= DAT_LO;
          end
          DAT_LO: if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= idx_q[ADDR_W-1:0];
            mem_wdata <= {hold_q, in_data};
            idx_q     <= idx_q + (ADDR_W+1)'(1);
            if (last_word) begin
              done  <= 1'b1;
              state <= RUN;
            end else begin
              state <= DAT_HI;
            end
          end
          RUN: ;   // back-pressure until reload
          ERR: ;   // swallow bytes until reload
          default: state <= CNT_HI;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed stimulus with a write scoreboard. The stimulus
// process pushes the expected memory writes; a monitor pops and compares
// every mem_we pulse on the falling clock edge.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              reload;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic              last;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .reload(reload), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_word(input logic [ADDR_W-1:0] a, input logic [15:0] d,
                             input logic last);
    wr_t w;
    w.addr = a; w.data = d; w.last = last;
    exp_q.push_back(w);
  endtask

  // Offer one byte after 'gap' idle cycles; returns at posedge+1 after the
  // accepting edge. Called and returning at posedge+1 phase.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL send_timeout: in_ready stuck at 0 for byte 0x%0h", b);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t w;
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                 mem_addr, mem_wdata);
      end else begin
        w = exp_q.pop_front();
        check("wr_addr", mem_addr, w.addr);
        check("wr_data", mem_wdata, w.data);
        check("wr_done", done, w.last);
        check("wr_cpu_hold", cpu_hold, !w.last);
      end
    end else if (rst_n === 1'b1 && done === 1'b1) begin
      errors++; checks++;
      $display("FAIL done_without_write: done=1 while mem_we=0");
    end
  end

  logic [7:0] nom [8];

  initial begin
    nom = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
    rst_n = 1'b0; reload = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal load at full rate.
    expect_word(0, 16'h1234, 0);
    expect_word(1, 16'hABCD, 0);
    expect_word(2, 16'h00FF, 1);
    foreach (nom[i]) send_byte(nom[i], 0);
    check("nom_in_ready_run", in_ready, 0);
    check("nom_cpu_hold_run", cpu_hold, 0);
    drain("nom_drain");
    // Bytes offered in RUN are back-pressured.
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (3) begin @(posedge clk); #1; end
    check("run_backpressure", in_ready, 0);
    in_valid = 1'b0;

    // Reload and a one-word image.
    pulse_reload();
    check("reload_cpu_hold", cpu_hold, 1);
    check("reload_in_ready", in_ready, 1);
    expect_word(0, 16'hBEEF, 1);
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hBE, 0); send_byte(8'hEF, 0);
    drain("reload_drain");
    check("reload_cpu_hold_run", cpu_hold, 0);

    // Same nominal stream with stalls.
    pulse_reload();
    expect_word(0, 16'h1234, 0);
    expect_word(1, 16'hABCD, 0);
    expect_word(2, 16'h00FF, 1);
    foreach (nom[i]) send_byte(nom[i], $urandom_range(0, 5));
    drain("stall_drain");
    check("stall_cpu_hold_run", cpu_hold, 0);

    // Bad header: zero count.
    pulse_reload();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    check("zero_err", err, 1);
    check("zero_cpu_hold", cpu_hold, 1);
    check("zero_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) send_byte(8'h11 * i[7:0], 0);
    check("zero_err_sticky", err, 1);

    // Bad header: one more than capacity.
    pulse_reload();
    check("reload_clears_err", err, 0);
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    check("over_err", err, 1);
    check("over_cpu_hold", cpu_hold, 1);
    for (int i = 0; i < 4; i++) send_byte(8'hF0 + i[7:0], 0);
    check("over_in_ready", in_ready, 1);

    // Full capacity: 256 words.
    pulse_reload();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = i[7:0];
      expect_word(a, {a, ~a}, i == 255);
      send_byte(a, 0);
      send_byte(~a, 0);
    end
    drain("full_drain");
    check("full_err", err, 0);
    check("full_cpu_hold_run", cpu_hold, 0);

    // Async reset between high and low data byte.
    pulse_reload();
    send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h55, 0);
    in_valid = 1'b1; in_data = 8'h66;
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_we", mem_we, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_mem_wdata", mem_wdata, 0);
    check("arst_cpu_hold", cpu_hold, 1);
    check("arst_in_ready", in_ready, 1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_word(0, 16'h1234, 1);
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    drain("arst_reload_drain");
    check("arst_final_err", err, 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
